// File: rtl/i2c_master_sequencer.sv
// Single-master I2C sequencer: one 7-bit address byte plus one data byte per command.
// SCL, START and STOP are generated from a quarter-period tick of CLK_DIV clk cycles.
module i2c_master_sequencer #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [6:0] cmd_addr,
    input  logic       cmd_rw,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       busy,
    inout  wire        scl,
    inout  wire        sda
);

    typedef enum logic [3:0] {
        IDLE, START, ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP, DONE
    } state_t;

    localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic [1:0] ph_q, ph_d;
    logic [2:0] bit_q, bit_d;
    logic [6:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rx_q, rx_d;
    logic [7:0] rdata_q, rdata_d;
    logic       nack_q, nack_d;
    logic       scl_low_q, scl_low_d;
    logic       sda_low_q, sda_low_d;
    logic       sda_in;
    logic [7:0] abyte;

    assign sda_in = sda;
    assign abyte  = {addr_q, rw_q};

    always_comb begin
        state_d   = state_q;
        qcnt_d    = qcnt_q;
        ph_d      = ph_q;
        bit_d     = bit_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        wdata_d   = wdata_q;
        rx_d      = rx_q;
        rdata_d   = rdata_q;
        nack_d    = nack_q;
        sda_low_d = sda_low_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    state_d = START;
                    addr_d  = cmd_addr;
                    rw_d    = cmd_rw;
                    wdata_d = cmd_wdata;
                    nack_d  = 1'b0;
                    qcnt_d  = '0;
                    ph_d    = '0;
                end
            end
            DONE: state_d = IDLE;
            default: begin
                if (qcnt_q != QMAX) begin
                    qcnt_d = qcnt_q + 8'd1;
                end else begin
                    qcnt_d = '0;
                    ph_d   = ph_q + 2'd1;
                    if (ph_q == 2'd3) begin
                        // End of a bit slot: advance the sequence, next slot starts at P0.
                        case (state_q)
                            START: begin
                                state_d = ADDR;
                                bit_d   = 3'd7;
                            end
                            ADDR: begin
                                if (bit_q == 3'd0) state_d = ADDR_ACK;
                                else               bit_d   = bit_q - 3'd1;
                            end
                            ADDR_ACK: begin
                                bit_d = 3'd7;
                                if (nack_q)    state_d = STOP;
                                else if (rw_q) state_d = RDATA;
                                else           state_d = WDATA;
                            end
                            WDATA: begin
                                if (bit_q == 3'd0) state_d = WACK;
                                else               bit_d   = bit_q - 3'd1;
                            end
                            RDATA: begin
                                if (bit_q == 3'd0) state_d = RNACK;
                                else               bit_d   = bit_q - 3'd1;
                            end
                            WACK, RNACK: state_d = STOP;
                            STOP: begin
                                state_d = DONE;
                                if (rw_q && !nack_q) rdata_d = rx_q;
                            end
                            default: state_d = IDLE;
                        endcase
                        if (state_d == STOP) sda_low_d = 1'b1;
                    end else begin
                        case (ph_d)
                            2'd1: begin
                                case (state_q)
                                    ADDR:                       sda_low_d = ~abyte[bit_q];
                                    WDATA:                      sda_low_d = ~wdata_q[bit_q];
                                    ADDR_ACK, WACK, RDATA, RNACK: sda_low_d = 1'b0;
                                    default: ;
                                endcase
                            end
                            2'd2: if (state_q == START) sda_low_d = 1'b1;
                            2'd3: begin
                                case (state_q)
                                    ADDR_ACK, WACK: if (sda_in) nack_d = 1'b1;
                                    RDATA:          rx_d = {rx_q[6:0], sda_in};
                                    STOP:           sda_low_d = 1'b0;
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
            end
        endcase

        // SCL is low in P0/P1 of every slot between START and the STOP release.
        scl_low_d = (state_d inside {ADDR, ADDR_ACK, WDATA, WACK, RDATA, RNACK, STOP})
                    && !ph_d[1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            qcnt_q    <= '0;
            ph_q      <= '0;
            bit_q     <= '0;
            nack_q    <= 1'b0;
            rdata_q   <= '0;
            scl_low_q <= 1'b0;
            sda_low_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            qcnt_q    <= qcnt_d;
            ph_q      <= ph_d;
            bit_q     <= bit_d;
            nack_q    <= nack_d;
            rdata_q   <= rdata_d;
            scl_low_q <= scl_low_d;
            sda_low_q <= sda_low_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        rw_q    <= rw_d;
        wdata_q <= wdata_d;
        rx_q    <= rx_d;
    end

    assign scl = scl_low_q ? 1'b0 : 1'bz;
    assign sda = sda_low_q ? 1'b0 : 1'bz;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_rdata = rdata_q;
    assign rsp_nack  = nack_q;

endmodule

// File: tb/tb_i2c_master_sequencer.sv
// Bench for i2c_master_sequencer: a behavioural slave at 7'h2A on bus A, plus two
// slave-less instances at CLK_DIV=2 and 255 for timing of the address-NACK path.
`timescale 1ns/1ps
module tb_i2c_master_sequencer;

    localparam int QA = 4;
    localparam int QB = 2;
    localparam int QC = 255;
    localparam logic [6:0] SLV_ADDR = 7'h2A;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    // ---------------- bus A: main instance with behavioural slave
    logic       a_valid = 1'b0;
    logic [6:0] a_addr  = '0;
    logic       a_rw    = 1'b0;
    logic [7:0] a_wdata = '0;
    logic       a_ready, a_rsp_valid, a_nack, a_busy;
    logic [7:0] a_rdata;
    wire scl_a, sda_a;
    pullup (scl_a);
    pullup (sda_a);

    i2c_master_sequencer #(.CLK_DIV(QA)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_addr(a_addr), .cmd_rw(a_rw), .cmd_wdata(a_wdata),
        .rsp_valid(a_rsp_valid), .rsp_rdata(a_rdata), .rsp_nack(a_nack),
        .busy(a_busy), .scl(scl_a), .sda(sda_a)
    );

    logic        slv_low = 1'b0;
    logic [7:0]  slv_byte = 8'hCC;
    logic [7:0]  slv_shift = '0, slv_addr_byte = '0, slv_wr_byte = '0;
    logic        slv_active = 1'b0, slv_read = 1'b0, slv_acked = 1'b0, slv_mack = 1'b0;
    int          slv_cnt = 0;
    int          starts_a = 0, stops_a = 0, hchg_a = 0;
    int unsigned rl_a = 0, rp_a = 0;
    logic        pscl_a = 1'b1, psda_a = 1'b1;

    assign sda_a = slv_low ? 1'b0 : 1'bz;

    // Slave reacts on negedge clk: reads bits on SCL rise, changes SDA right after SCL falls.
    always @(negedge clk) begin
        pscl_a <= scl_a;
        psda_a <= sda_a;
        if (pscl_a && scl_a && (psda_a != sda_a)) hchg_a <= hchg_a + 1;
        if (pscl_a && scl_a && psda_a && !sda_a) begin
            starts_a   <= starts_a + 1;
            slv_active <= 1'b1;
            slv_cnt    <= 0;
            slv_low    <= 1'b0;
            slv_acked  <= 1'b0;
            slv_read   <= 1'b0;
        end else if (pscl_a && scl_a && !psda_a && sda_a) begin
            stops_a    <= stops_a + 1;
            slv_active <= 1'b0;
            slv_low    <= 1'b0;
        end else if (!pscl_a && scl_a) begin
            rp_a <= rl_a;
            rl_a <= cyc;
            if (slv_active) begin
                slv_cnt <= slv_cnt + 1;
                if (slv_cnt < 8 || (slv_cnt >= 9 && slv_cnt < 17))
                    slv_shift <= {slv_shift[6:0], sda_a};
                if (slv_cnt == 7)  slv_addr_byte <= {slv_shift[6:0], sda_a};
                if (slv_cnt == 16) slv_wr_byte   <= {slv_shift[6:0], sda_a};
                if (slv_cnt == 17) slv_mack      <= sda_a;
            end
        end else if (slv_active && pscl_a && !scl_a) begin
            if (slv_cnt == 8) begin
                slv_read  <= slv_addr_byte[0];
                slv_acked <= (slv_addr_byte[7:1] == SLV_ADDR);
                slv_low   <= (slv_addr_byte[7:1] == SLV_ADDR);
            end else if (slv_acked && slv_read && slv_cnt >= 9 && slv_cnt <= 16) begin
                slv_low <= !slv_byte[3'(16 - slv_cnt)];
            end else if (slv_acked && !slv_read && slv_cnt == 17) begin
                slv_low <= 1'b1;
            end else begin
                slv_low <= 1'b0;
            end
        end
    end

    // ---------------- buses B and C: no slave, timing only
    logic       b_valid = 1'b0, c_valid = 1'b0;
    logic [6:0] probe_addr = 7'h11;
    logic       probe_rw = 1'b0;
    logic [7:0] probe_wdata = 8'h00;
    logic       b_ready, b_rsp_valid, b_nack, b_busy;
    logic       c_ready, c_rsp_valid, c_nack, c_busy;
    logic [7:0] b_rdata, c_rdata;
    wire scl_b, sda_b, scl_c, sda_c;
    pullup (scl_b);
    pullup (sda_b);
    pullup (scl_c);
    pullup (sda_c);

    i2c_master_sequencer #(.CLK_DIV(QB)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_addr(probe_addr), .cmd_rw(probe_rw), .cmd_wdata(probe_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .rsp_nack(b_nack),
        .busy(b_busy), .scl(scl_b), .sda(sda_b)
    );

    i2c_master_sequencer #(.CLK_DIV(QC)) dut_c (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(c_valid), .cmd_ready(c_ready),
        .cmd_addr(probe_addr), .cmd_rw(probe_rw), .cmd_wdata(probe_wdata),
        .rsp_valid(c_rsp_valid), .rsp_rdata(c_rdata), .rsp_nack(c_nack),
        .busy(c_busy), .scl(scl_c), .sda(sda_c)
    );

    logic        pscl_b = 1'b1, psda_b = 1'b1, pscl_c = 1'b1, psda_c = 1'b1;
    int          hchg_b = 0, hchg_c = 0;
    int unsigned rl_b = 0, rp_b = 0, rl_c = 0, rp_c = 0;

    always @(negedge clk) begin
        pscl_b <= scl_b;
        psda_b <= sda_b;
        pscl_c <= scl_c;
        psda_c <= sda_c;
        if (pscl_b && scl_b && (psda_b != sda_b)) hchg_b <= hchg_b + 1;
        if (pscl_c && scl_c && (psda_c != sda_c)) hchg_c <= hchg_c + 1;
        if (!pscl_b && scl_b) begin rp_b <= rl_b; rl_b <= cyc; end
        if (!pscl_c && scl_c) begin rp_c <= rl_c; rl_c <= cyc; end
    end

    // ---------------- checking helpers and reference model
    logic [7:0] exp_rdata = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the first negedge after acceptance; returns the cycle index of rsp_valid.
    task automatic wait_rsp(input int bound, output int n, output bit hold_ok);
        n = 1;
        hold_ok = 1'b1;
        while (a_rsp_valid !== 1'b1 && n < bound) begin
            if (a_busy !== 1'b1 || a_ready !== 1'b0) hold_ok = 1'b0;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_a(input logic [6:0] addr, input logic rw,
                         input logic [7:0] wd, input logic [7:0] sb);
        int n, lat, h0, s0, p0;
        bit hold_ok, match;
        match = (addr == SLV_ADDR);
        lat   = match ? 80 * QA : 44 * QA;
        @(negedge clk);
        check("ready_before", a_ready, 1);
        slv_byte = sb;
        a_addr   = addr;
        a_rw     = rw;
        a_wdata  = wd;
        a_valid  = 1'b1;
        h0 = hchg_a; s0 = starts_a; p0 = stops_a;
        @(negedge clk);
        a_valid = 1'b0;
        wait_rsp(lat + 20, n, hold_ok);
        if (rw && match) exp_rdata = sb;
        check("busy_during", hold_ok, 1);
        check("latency", n, lat + 1);
        check("busy_at_rsp", a_busy, 1);
        check("rsp_nack", a_nack, !match);
        check("rsp_rdata", a_rdata, exp_rdata);
        check("addr_byte", slv_addr_byte, {addr, rw});
        if (match && !rw) check("slave_wr_byte", slv_wr_byte, wd);
        if (match && rw)  check("master_nack", slv_mack, 1);
        check("start_stop", (starts_a - s0) * 16 + (stops_a - p0), 17);
        check("sda_chg_scl_hi", hchg_a - h0, 2);
        check("bit_period", rl_a - rp_a, 4 * QA);
        @(negedge clk);
        check("busy_idle", a_busy, 0);
        check("ready_idle", a_ready, 1);
        check("rsp_pulse", a_rsp_valid, 0);
    endtask

    task automatic probe(input int q, input bit use_c);
        int n, h0;
        @(negedge clk);
        check("probe_ready", use_c ? c_ready : b_ready, 1);
        h0 = use_c ? hchg_c : hchg_b;
        if (use_c) c_valid = 1'b1; else b_valid = 1'b1;
        @(negedge clk);
        b_valid = 1'b0;
        c_valid = 1'b0;
        n = 1;
        while ((use_c ? c_rsp_valid : b_rsp_valid) !== 1'b1 && n < 50 * q + 50) begin
            @(negedge clk);
            n++;
        end
        check(use_c ? "lat_div255" : "lat_div2", n, 44 * q + 1);
        check(use_c ? "nack_div255" : "nack_div2", use_c ? c_nack : b_nack, 1);
        check(use_c ? "period_div255" : "period_div2",
              use_c ? (rl_c - rp_c) : (rl_b - rp_b), 4 * q);
        check(use_c ? "sda_chg_div255" : "sda_chg_div2",
              (use_c ? hchg_c : hchg_b) - h0, 2);
    endtask

    // ---------------- directed sequence
    initial begin
        int n, s0;
        bit hold_ok, no_rsp;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_scl", scl_a, 1);
        check("rst_sda", sda_a, 1);
        check("rst_ready", a_ready, 1);
        check("rst_busy", a_busy, 0);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rsp_nack", a_nack, 0);
        check("rst_rdata", a_rdata, 0);

        run_a(SLV_ADDR, 1'b0, 8'hA5, 8'hCC);
        run_a(SLV_ADDR, 1'b1, 8'h00, 8'hCC);
        run_a(7'h11,    1'b1, 8'h00, 8'h5A);
        run_a(7'h11,    1'b0, 8'hFF, 8'h5A);

        // cmd_valid held through a whole transaction with wdata changing underneath.
        @(negedge clk);
        a_addr = SLV_ADDR; a_rw = 1'b0; a_wdata = 8'h3C; a_valid = 1'b1;
        s0 = starts_a;
        @(negedge clk);
        a_wdata = 8'h96;
        wait_rsp(80 * QA + 20, n, hold_ok);
        check("b2b_hold1", hold_ok, 1);
        check("b2b_lat1", n, 80 * QA + 1);
        check("b2b_byte1", slv_wr_byte, 8'h3C);
        check("b2b_starts1", starts_a - s0, 1);
        @(negedge clk);
        check("b2b_idle_busy", a_busy, 0);
        check("b2b_idle_ready", a_ready, 1);
        @(negedge clk);
        check("b2b_accept2", a_busy, 1);
        a_valid = 1'b0;
        wait_rsp(80 * QA + 20, n, hold_ok);
        check("b2b_lat2", n, 80 * QA + 1);
        check("b2b_byte2", slv_wr_byte, 8'h96);
        @(negedge clk);

        // Reset in P1 of a write data slot (SCL low).
        @(negedge clk);
        a_addr = SLV_ADDR; a_rw = 1'b0; a_wdata = 8'hA5; a_valid = 1'b1;
        @(negedge clk);
        a_valid = 1'b0;
        repeat (49 * QA + 1) @(negedge clk);
        check("abort_busy_before", a_busy, 1);
        check("abort_scl_low", scl_a, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_scl", scl_a, 1);
        check("abort_sda", sda_a, 1);
        check("abort_busy", a_busy, 0);
        check("abort_ready", a_ready, 1);
        check("abort_rsp_valid", a_rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_rdata = 8'h00;
        no_rsp = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (a_rsp_valid !== 1'b0) no_rsp = 1'b0;
        end
        check("abort_no_rsp", no_rsp, 1);
        check("abort_rdata", a_rdata, 0);
        run_a(SLV_ADDR, 1'b0, 8'h81, 8'h00);

        // Randomized commands against the reference expectations.
        for (int i = 0; i < 8; i++) begin
            logic [6:0] ra;
            ra = ($urandom_range(0, 1) == 1) ? SLV_ADDR : 7'($urandom_range(0, 127));
            run_a(ra, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
        end

        probe(QB, 1'b0);
        probe(QC, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
